// File: rtl/muldiv_pkg.sv
// Shared types, constants and helpers for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_t;

  typedef enum logic [1:0] {
    DV_IDLE = 2'd0,
    DV_STEP = 2'd1,
    DV_FIX  = 2'd2
  } dv_phase_t;

  localparam int          DIV_STEPS = 32;
  localparam logic [31:0] DIV0_Q    = 32'hFFFF_FFFF;

  // Magnitude of a two's-complement value when signed; 0x8000_0000 maps onto itself.
  function automatic logic [31:0] md_abs(input logic [31:0] x, input logic is_signed);
    md_abs = (is_signed && x[31]) ? (32'd0 - x) : x;
  endfunction

  // 64-bit extension so a single truncated 64x64 multiply serves both signednesses.
  function automatic logic [63:0] md_ext(input logic [31:0] x, input logic is_signed);
    md_ext = is_signed ? {{32{x[31]}}, x} : {32'd0, x};
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Iterative 32-step restoring divider with a final sign fix-up cycle.
module muldiv_div_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        kill,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        is_signed,
  output logic [31:0] q,
  output logic [31:0] r,
  output logic        valid
);

  dv_phase_t   phase_r;
  logic [5:0]  cnt_r;
  logic [31:0] quo_r;
  logic [31:0] rem_r;
  logic [31:0] dvs_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic [32:0] trial_s;

  // Shift the next dividend bit into the partial remainder and try subtracting the divisor.
  assign trial_s = {rem_r, quo_r[31]} - {1'b0, dvs_r};

  // Divider sequencing: latch magnitudes, run the steps, then present the fixed-up result.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_r <= DV_IDLE;
      cnt_r   <= 6'd0;
      quo_r   <= 32'd0;
      rem_r   <= 32'd0;
      dvs_r   <= 32'd0;
      neg_q_r <= 1'b0;
      neg_r_r <= 1'b0;
    end else if (kill) begin
      phase_r <= DV_IDLE;
      cnt_r   <= 6'd0;
    end else begin
      case (phase_r)
        DV_IDLE: begin
          if (start) begin
            quo_r   <= md_abs(a, is_signed);
            dvs_r   <= md_abs(b, is_signed);
            rem_r   <= 32'd0;
            neg_q_r <= is_signed && (a[31] ^ b[31]);
            neg_r_r <= is_signed && a[31];
            cnt_r   <= 6'd0;
            phase_r <= DV_STEP;
          end
        end
        DV_STEP: begin
          if (!trial_s[32]) begin
            rem_r <= trial_s[31:0];
            quo_r <= {quo_r[30:0], 1'b1};
          end else begin
            rem_r <= {rem_r[30:0], quo_r[31]};
            quo_r <= {quo_r[30:0], 1'b0};
          end
          if (cnt_r == 6'(DIV_STEPS - 1)) begin
            phase_r <= DV_FIX;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        DV_FIX:  phase_r <= DV_IDLE;
        default: phase_r <= DV_IDLE;
      endcase
    end
  end

  assign valid = (phase_r == DV_FIX);
  assign q     = neg_q_r ? (32'd0 - quo_r) : quo_r;
  assign r     = neg_r_r ? (32'd0 - rem_r) : rem_r;

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO multiply/divide sequencer: owns HI/LO, runs MUL/DIV, raises busy for the hazard unit.
// Optional abort input is enabled by defining MULDIV_FLUSH_EN.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
`ifdef MULDIV_FLUSH_EN
  input  logic            flush,
`endif
  output logic            req_ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  md_state_t   state_r;
  logic [3:0]  cnt_r;
  logic [31:0] op_a_r;
  logic [31:0] op_b_r;
  logic        mul_signed_r;
  logic        div0_r;
  logic        done_r;
  logic [31:0] hi_r;
  logic [31:0] lo_r;

  md_op_t      op_s;
  logic        flush_s;
  logic        div_start_s;
  logic [63:0] prod_s;
  logic [31:0] dq_s;
  logic [31:0] dr_s;
  logic        dvalid_s;

`ifdef MULDIV_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  assign op_s        = md_op_t'(req_op);
  assign div_start_s = req_valid && (state_r == ST_IDLE) && !flush_s &&
                       ((op_s == MD_DIV) || (op_s == MD_DIVU)) && (req_b != 32'd0);
  assign prod_s      = md_ext(op_a_r, mul_signed_r) * md_ext(op_b_r, mul_signed_r);

  muldiv_div_core u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start_s),
    .kill      (flush_s),
    .a         (req_a),
    .b         (req_b),
    .is_signed (op_s == MD_DIV),
    .q         (dq_s),
    .r         (dr_s),
    .valid     (dvalid_s)
  );

  // Main FSM with HI/LO ownership; results land in HI/LO only on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 4'd0;
      op_a_r       <= 32'd0;
      op_b_r       <= 32'd0;
      mul_signed_r <= 1'b0;
      div0_r       <= 1'b0;
      done_r       <= 1'b0;
      hi_r         <= 32'd0;
      lo_r         <= 32'd0;
    end else if (flush_s) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      div0_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            case (op_s)
              MD_MTHI: hi_r <= req_a;
              MD_MTLO: lo_r <= req_a;
              MD_MULT, MD_MULTU: begin
                op_a_r       <= req_a;
                op_b_r       <= req_b;
                mul_signed_r <= (op_s == MD_MULT);
                cnt_r        <= 4'(MUL_LAT - 1);
                state_r      <= ST_MUL;
              end
              MD_DIV, MD_DIVU: begin
                op_a_r  <= req_a;
                div0_r  <= (req_b == 32'd0);
                state_r <= ST_DIV;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: begin
          if (cnt_r == 4'd0) begin
            {hi_r, lo_r} <= prod_s;
            done_r       <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_DIV: begin
          // Divide by zero never starts the core and resolves in its first busy cycle.
          if (div0_r) begin
            hi_r    <= op_a_r;
            lo_r    <= DIV0_Q;
            div0_r  <= 1'b0;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end else if (dvalid_s) begin
            hi_r    <= dr_s;
            lo_r    <= dq_s;
            done_r  <= 1'b1;
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign req_ready = (state_r == ST_IDLE);
  assign busy      = ~req_ready;
  assign done      = done_r;
  assign hi        = hi_r;
  assign lo        = lo_r;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed table, corner sequences, random ops vs. a reference model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_ready;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef MULDIV_FLUSH_EN
  logic        flush;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  typedef struct {
    md_op_t      op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    int          lat;
  } vec_t;

  vec_t vecs[9];

  always #5 clk = ~clk;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT), .XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
`ifdef MULDIV_FLUSH_EN
    .flush     (flush),
`endif
    .req_ready (req_ready),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Architectural result {hi, lo} of one op, from plain integer arithmetic.
  function automatic logic [63:0] ref_result(input md_op_t op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [31:0] ch,
                                             input logic [31:0] cl);
    longint sa;
    longint sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MD_MTHI:  ref_result = {a, cl};
      MD_MTLO:  ref_result = {ch, a};
      MD_MULT:  begin p = 64'(sa * sb); ref_result = p; end
      MD_MULTU: begin p = {32'd0, a} * {32'd0, b}; ref_result = p; end
      MD_DIV:   ref_result = (b == 32'd0) ? {a, 32'hFFFF_FFFF}
                                          : {32'(sa % sb), 32'(sa / sb)};
      MD_DIVU:  ref_result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      default:  ref_result = {ch, cl};
    endcase
  endfunction

  function automatic int ref_lat(input md_op_t op, input logic [31:0] b);
    case (op)
      MD_MULT, MD_MULTU: ref_lat = MUL_LAT;
      MD_DIV, MD_DIVU:   ref_lat = (b == 32'd0) ? 1 : 33;
      default:           ref_lat = 0;
    endcase
  endfunction

  // Present one op at a negedge; returns at the negedge after the accepting edge.
  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ehi, input logic [31:0] elo, input int lat,
                        input string tag);
    int   nb;
    logic stable;
    logic [31:0] ph;
    logic [31:0] pl;
    ph = m_hi;
    pl = m_lo;
    start_op(op, a, b);
    nb     = 0;
    stable = 1'b1;
    while (busy && nb < 100) begin
      if (hi !== ph || lo !== pl || done !== 1'b0) stable = 1'b0;
      nb++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(nb), 64'(lat));
    check({tag, "_hilo_stable"}, {63'd0, stable}, 64'd1);
    check({tag, "_hilo"}, {hi, lo}, {ehi, elo});
    check({tag, "_ready"}, {63'd0, req_ready}, 64'd1);
    check({tag, "_done"}, {63'd0, done}, (lat == 0) ? 64'd0 : 64'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    m_hi = ehi;
    m_lo = elo;
  endtask

  initial begin
    md_op_t      rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [63:0] exp;

    vecs[0] = '{MD_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT};
    vecs[1] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33};
    vecs[3] = '{MD_DIVU,  32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 32'hFFFF_FFFF, 1};
    vecs[4] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 33};
    vecs[5] = '{MD_DIVU,  32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 33};
    vecs[6] = '{MD_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33};
    vecs[7] = '{MD_DIV,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 1};
    vecs[8] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, MUL_LAT};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 3'd0;
    req_a     = 32'd0;
    req_b     = 32'd0;
`ifdef MULDIV_FLUSH_EN
    flush     = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_state", {hi, lo}, 64'd0);
    check("reset_flags", {61'd0, req_ready, busy, done}, {61'd0, 3'b100});

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].lat,
             $sformatf("vec%0d", i));
    end

    run_op(MD_MTHI, 32'h0000_1234, 32'd0, 32'h0000_1234, m_lo, 0, "mthi");
    run_op(MD_MTLO, 32'hCAFE_0001, 32'd0, m_hi, 32'hCAFE_0001, 0, "mtlo");

    // Unknown opcode changes nothing.
    start_op(3'd6, 32'hDEAD_BEEF, 32'h1);
    check("unknown_op", {hi, lo, 30'd0, req_ready, busy}, {m_hi, m_lo, 30'd0, 2'b10});

    // Op held on the bus while busy must not be taken until req_ready.
    start_op(MD_MULTU, 32'd5, 32'd6);
    req_valid = 1'b1;
    req_op    = MD_MTHI;
    req_a     = 32'hDEAD_0000;
    for (int n = 0; n < 100 && busy; n++) @(negedge clk);
    req_valid = 1'b0;
    check("held_op_ignored", {hi, lo}, {32'd0, 32'd30});
    m_hi = 32'd0;
    m_lo = 32'd30;
    @(negedge clk);

    // Reset in the middle of a divide.
    start_op(MD_DIV, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_mid_div", {hi, lo, 31'd0, req_ready}, {64'd0, 32'd1});
    m_hi = 32'd0;
    m_lo = 32'd0;
    run_op(MD_MTLO, 32'h5555_AAAA, 32'd0, 32'd0, 32'h5555_AAAA, 0, "mtlo_after_reset");

`ifdef MULDIV_FLUSH_EN
    start_op(MD_DIV, 32'd1000, 32'd7);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_mid_div", {hi, lo, 30'd0, req_ready, done}, {m_hi, m_lo, 32'd2});
    req_valid = 1'b1;
    req_op    = MD_MULT;
    req_a     = 32'd3;
    req_b     = 32'd3;
    flush     = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    flush     = 1'b0;
    check("flush_blocks_accept", {63'd0, busy}, 64'd0);
`endif

    for (int k = 0; k < 40; k++) begin
      rop = md_op_t'(3'($urandom_range(0, 5)));
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      exp = ref_result(rop, ra, rb, m_hi, m_lo);
      run_op(rop, ra, rb, exp[63:32], exp[31:0], ref_lat(rop, rb), $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
